piso_shift_reg: RTL and testbench

Parallel-in/serial-out shift register built as the storage stage directly downstream of the team's single-bit D flip-flop cell. It accepts a WIDTH-bit word through a valid/ready handshake and emits it LSB-first, one bit per accepted serial beat, with its own valid/ready handshake. It sits between a word-wide producer and a bit-serial consumer, such as a serial link or a bit-serial ALU.

---
 rtl/piso_shift_reg_pkg.sv | 14 +
 rtl/piso_shift_reg_if.sv | 38 +++
 rtl/piso_shift_reg_dff_cell.sv | 21 ++
 rtl/piso_shift_reg.sv | 87 ++++++++
 tb/tb_piso_shift_reg.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/piso_shift_reg_pkg.sv
// Shared types and helpers for the PISO shift register.
// State encoding and counter sizing live here.
package piso_shift_reg_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    function automatic int cnt_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/piso_shift_reg_if.sv
// Word-side and serial-side handshake bundle.
// The DUT uses the slave modport, the producer/consumer the master.
interface piso_shift_reg_if #(
    parameter int WIDTH = 8
) ();

    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] load_data;
    logic             ser_valid;
    logic             ser_ready;
    logic             ser_out;
    logic             ser_last;
    logic             busy;

    modport master (
        output load_valid,
        output load_data,
        output ser_ready,
        input  load_ready,
        input  ser_valid,
        input  ser_out,
        input  ser_last,
        input  busy
    );

    modport slave (
        input  load_valid,
        input  load_data,
        input  ser_ready,
        output load_ready,
        output ser_valid,
        output ser_out,
        output ser_last,
        output busy
    );

endinterface

// File: rtl/piso_shift_reg_dff_cell.sv
// Single storage bit: async active-low reset, sync clear.
// All PISO state is built from these cells.
module dff_cell (
    input  logic clk,
    input  logic Re,
    input  logic clr,
    input  logic d,
    output logic q
);

    always_ff @(posedge clk or negedge Re) begin
        if (!Re) begin
            q <= 1'b0;
        end else if (clr) begin
            q <= 1'b0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/piso_shift_reg.sv
// Parallel-in/serial-out shift register, LSB first, with
// zero-bubble reload on the final serial beat.
import piso_shift_reg_pkg::*;

module piso_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              Re,
    input  logic              inz,
    piso_shift_reg_if.slave   bus
);

    localparam int CW = cnt_width(WIDTH);
    localparam int NB = WIDTH + CW + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [NB-1:0]    q;
    logic [NB-1:0]    d;
    logic [WIDTH-1:0] sh;
    logic [CW-1:0]    cnt;
    state_e           state;

    logic [WIDTH-1:0] sh_d;
    logic [CW-1:0]    cnt_d;
    state_e           state_d;
    logic             in_shift;
    logic             final_beat;
    logic             rdy;
    logic             load;
    logic             beat;

    assign sh    = q[WIDTH-1:0];
    assign cnt   = q[WIDTH+CW-1:WIDTH];
    assign state = state_e'(q[NB-1]);

    // Layout of the cell vector: {state, counter, shift register}
    for (genvar i = 0; i < NB; i++) begin : g_bit
        dff_cell u_cell (
            .clk (clk),
            .Re  (Re),
            .clr (inz),
            .d   (d[i]),
            .q   (q[i])
        );
    end

    always_comb begin
        sh_d       = sh;
        cnt_d      = cnt;
        state_d    = state;
        in_shift   = (state == SHIFT);
        final_beat = in_shift && (cnt == LAST);
        rdy        = Re && !inz &&
                     (!in_shift ||
                      (bus.ser_ready && final_beat));
        load       = rdy && bus.load_valid;
        beat       = in_shift && bus.ser_ready && !load;

        unique case (1'b1)
            load: begin
                sh_d    = bus.load_data;
                cnt_d   = '0;
                state_d = SHIFT;
            end
            beat: begin
                sh_d = {1'b0, sh[WIDTH-1:1]};
                if (final_beat) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            default: ;
        endcase

        d = {state_d, cnt_d, sh_d};
    end

    assign bus.load_ready = rdy;
    assign bus.ser_valid  = in_shift;
    assign bus.busy       = in_shift;
    assign bus.ser_out    = sh[0];
    assign bus.ser_last   = final_beat;

endmodule

// File: tb/tb_piso_shift_reg.sv
// Directed, table-driven bench for piso_shift_reg.
// Expected bit streams are written out by hand per word.
module tb_piso_shift_reg;

    typedef struct {
        logic       lv;
        logic [7:0] ld;
        logic       sr;
        logic       iz;
        logic [4:0] exp;
        string      nm;
    } vec_t;

    logic clk = 1'b0;
    logic Re  = 1'b0;
    logic inz = 1'b0;

    int n_run  = 0;
    int n_fail = 0;

    vec_t tbl[$];

    always #5 clk = ~clk;

    piso_shift_reg_if #(.WIDTH(8)) bus ();

    piso_shift_reg #(.WIDTH(8)) dut (
        .clk (clk),
        .Re  (Re),
        .inz (inz),
        .bus (bus.slave)
    );

    // {load_ready, ser_valid, ser_out, ser_last, busy}
    function automatic logic [4:0] outs();
        return {bus.load_ready, bus.ser_valid, bus.ser_out,
                bus.ser_last, bus.busy};
    endfunction

    task automatic chk(input string nm, input logic [4:0] got,
                       input logic [4:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s rdy/vld/out/last/busy got %b expected %b",
                     nm, got, exp);
        end
    endtask

    function automatic void add(input string nm, input logic lv,
                                input logic [7:0] ld, input logic sr,
                                input logic iz, input logic [4:0] e);
        vec_t v;
        v.nm  = nm;
        v.lv  = lv;
        v.ld  = ld;
        v.sr  = sr;
        v.iz  = iz;
        v.exp = e;
        tbl.push_back(v);
    endfunction

    // One row per accepted beat; bits lists ser_out in emission order.
    function automatic void add_beats(input string nm, input string bits,
                                      input logic lv, input logic [7:0] ld,
                                      input logic ends);
        for (int i = 0; i < bits.len(); i++) begin
            logic b;
            logic l;
            b = (bits[i] == "1");
            l = ends && (i == bits.len() - 1);
            add($sformatf("%s_b%0d", nm, i + 1), lv, ld, 1'b1, 1'b0,
                {l, 1'b1, b, l, 1'b1});
        end
    endfunction

    task automatic run_row(input vec_t v);
        bus.load_valid = v.lv;
        bus.load_data  = v.ld;
        bus.ser_ready  = v.sr;
        inz            = v.iz;
        #2;
        chk(v.nm, outs(), v.exp);
        @(posedge clk);
        #1;
    endtask

    task automatic run_table();
        for (int i = 0; i < tbl.size(); i++) begin
            run_row(tbl[i]);
        end
        tbl.delete();
    endtask

    initial begin
        bus.load_valid = 1'b1;
        bus.load_data  = 8'hFF;
        bus.ser_ready  = 1'b1;

        for (int i = 0; i < 3; i++) begin
            #3;
            chk($sformatf("rst_c%0d", i), outs(), 5'b00000);
            @(posedge clk);
            #1;
        end
        Re             = 1'b1;
        bus.load_valid = 1'b0;
        #2;
        chk("rst_release", outs(), 5'b10000);
        @(posedge clk);
        #1;

        add("a5_load", 1'b1, 8'hA5, 1'b1, 1'b0, 5'b10000);
        add_beats("a5", "10100101", 1'b0, 8'h00, 1'b1);
        add("a5_idle", 1'b0, 8'h00, 1'b1, 1'b0, 5'b10000);

        add("81_load", 1'b1, 8'h81, 1'b1, 1'b0, 5'b10000);
        add("81_stall1", 1'b0, 8'h00, 1'b0, 1'b0, 5'b01101);
        add("81_stall2", 1'b0, 8'h00, 1'b0, 1'b0, 5'b01101);
        add("81_stall3", 1'b0, 8'h00, 1'b0, 1'b0, 5'b01101);
        add_beats("81", "10000001", 1'b0, 8'h00, 1'b1);
        add("81_idle", 1'b0, 8'h00, 1'b1, 1'b0, 5'b10000);

        add("3c_load", 1'b1, 8'h3C, 1'b1, 1'b0, 5'b10000);
        add_beats("3c", "00111100", 1'b1, 8'hFF, 1'b1);
        add_beats("ff", "11111111", 1'b0, 8'h00, 1'b1);
        add("ff_idle", 1'b0, 8'h00, 1'b1, 1'b0, 5'b10000);

        add("f0_load", 1'b1, 8'hF0, 1'b1, 1'b0, 5'b10000);
        add("f0_b1", 1'b0, 8'h00, 1'b1, 1'b0, 5'b01001);
        add("f0_b2", 1'b0, 8'h00, 1'b1, 1'b0, 5'b01001);
        add("f0_b3_inz", 1'b1, 8'h77, 1'b1, 1'b1, 5'b01001);
        add("f0_cleared", 1'b0, 8'h00, 1'b1, 1'b0, 5'b10000);
        add("01_load", 1'b1, 8'h01, 1'b1, 1'b0, 5'b10000);
        add_beats("01", "10000000", 1'b0, 8'h00, 1'b1);
        add("01_idle", 1'b0, 8'h00, 1'b1, 1'b0, 5'b10000);

        add("c3_load", 1'b1, 8'hC3, 1'b1, 1'b0, 5'b10000);
        add_beats("c3", "1100", 1'b0, 8'h00, 1'b0);
        run_table();

        bus.load_valid = 1'b0;
        bus.ser_ready  = 1'b1;
        #2;
        chk("c3_b5", outs(), 5'b01001);
        #1;
        Re = 1'b0;
        #1;
        chk("async_rst", outs(), 5'b00000);
        @(posedge clk);
        #1;
        chk("async_hold", outs(), 5'b00000);
        Re = 1'b1;

        add("5a_load", 1'b1, 8'h5A, 1'b1, 1'b0, 5'b10000);
        add_beats("5a", "01011010", 1'b0, 8'h00, 1'b1);
        add("5a_idle", 1'b0, 8'h00, 1'b1, 1'b0, 5'b10000);
        run_table();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
